mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_pkg.sv | 17 +
 rtl/mem_access_ctrl_io_port_bank.sv | 28 ++
 rtl/mem_access_ctrl.sv | 134 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the serialised memory access controller.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } state_t;

  localparam int unsigned IO_WINDOW = 16;

  // First address of the I/O window: the top IO_WINDOW words of the address space.
  function automatic logic [31:0] io_base(input int unsigned size_log);
    return (32'd1 << size_log) - IO_WINDOW;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_io_port_bank.sv
// Memory-mapped I/O bank: io_out register file plus io_in word selection.
// Only instantiated when MEM_ACCESS_IO_MAP_EN is defined.
module io_port_bank
  import mem_access_pkg::*;
#(
  parameter int WORD = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [3:0]                index,
  input  logic [WORD-1:0]           wdata,
  input  logic [IO_WINDOW*WORD-1:0] io_in,
  output logic [IO_WINDOW*WORD-1:0] io_out,
  output logic [WORD-1:0]           rd_data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      io_out <= '0;
    end else if (wr_en) begin
      io_out[int'(index)*WORD +: WORD] <= wdata;
    end
  end

  assign rd_data = io_in[int'(index)*WORD +: WORD];

endmodule

// File: rtl/mem_access_ctrl.sv
// Serialised load/store controller between a core and a registered-read RAM.
// Define MEM_ACCESS_IO_MAP_EN to map the top 16 addresses onto io_in/io_out.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int WORD     = 1,
  parameter int SIZE_LOG = 12
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [SIZE_LOG-1:0] req_addr,
  input  logic [WORD-1:0]     req_wdata,
  output logic                rsp_valid,
  output logic [WORD-1:0]     rsp_data,
  output logic                ram_read,
  output logic                ram_write,
  output logic [SIZE_LOG-1:0] ram_address,
  output logic [WORD-1:0]     ram_data_in,
  input  logic [WORD-1:0]     ram_data_out
`ifdef MEM_ACCESS_IO_MAP_EN
  ,
  input  logic [IO_WINDOW*WORD-1:0] io_in,
  output logic [IO_WINDOW*WORD-1:0] io_out
`endif
);

  state_t          state;
  logic            ready_q;
  logic            valid_q;
  logic            wr_q;
  logic [WORD-1:0] rsp_q;
  logic [WORD-1:0] cap_data;
  logic            addr_io;
  logic            accept;

  assign accept = (state == IDLE) && ready_q && req_valid;

`ifdef MEM_ACCESS_IO_MAP_EN
  logic            io_q;
  logic            io_wr;
  logic [WORD-1:0] io_rd;
  logic [WORD-1:0] io_sample;

  assign addr_io  = (32'(req_addr) >= io_base(SIZE_LOG));
  assign io_wr    = (state == ISSUE) && wr_q && io_q;
  assign cap_data = io_q ? io_sample : ram_data_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      io_q      <= 1'b0;
      io_sample <= '0;
    end else begin
      if (accept) io_q <= addr_io;
      if (state == ISSUE) io_sample <= io_rd;
    end
  end

  io_port_bank #(
    .WORD(WORD)
  ) u_io_port_bank (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (io_wr),
    .index  (ram_address[3:0]),
    .wdata  (ram_data_in),
    .io_in  (io_in),
    .io_out (io_out),
    .rd_data(io_rd)
  );
`else
  assign addr_io  = 1'b0;
  assign cap_data = ram_data_out;
`endif

  // ram_address / ram_data_in double as the registered request fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      wr_q        <= 1'b0;
      rsp_q       <= '0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= ISSUE;
            ready_q     <= 1'b0;
            wr_q        <= req_write;
            ram_address <= req_addr;
            if (req_write) ram_data_in <= req_wdata;
            ram_read    <= !req_write && !addr_io;
            ram_write   <= req_write && !addr_io;
          end
        end
        ISSUE: begin
          ram_read  <= 1'b0;
          ram_write <= 1'b0;
          if (wr_q) begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end else begin
            state   <= CAPTURE;
            valid_q <= 1'b1;
          end
        end
        CAPTURE: begin
          valid_q <= 1'b0;
          rsp_q   <= cap_data;
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // RAM data only arrives during CAPTURE, so it is forwarded then and held afterwards;
  // a reset landing in CAPTURE suppresses the pulse of the aborted load.
  assign req_ready = ready_q;
  assign rsp_valid = valid_q && !reset;
  assign rsp_data  = (state == CAPTURE) ? cap_data : rsp_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomised self-checking bench for mem_access_ctrl with a behavioural RAM/I-O model.
module tb_mem_access_ctrl;
  localparam int WORD     = 1;
  localparam int SIZE_LOG = 12;
  localparam int DEPTH    = 1 << SIZE_LOG;
`ifdef MEM_ACCESS_IO_MAP_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_write = 1'b0;
  logic [SIZE_LOG-1:0] req_addr = '0;
  logic [WORD-1:0]     req_wdata = '0;
  logic                req_ready;
  logic                rsp_valid;
  logic [WORD-1:0]     rsp_data;
  logic                ram_read;
  logic                ram_write;
  logic [SIZE_LOG-1:0] ram_address;
  logic [WORD-1:0]     ram_data_in;
  logic [WORD-1:0]     ram_data_out = '0;

  logic [WORD-1:0] ram     [DEPTH] = '{default: '0};
  logic [WORD-1:0] ref_mem [DEPTH] = '{default: '0};
`ifdef MEM_ACCESS_IO_MAP_EN
  logic [16*WORD-1:0] io_in = '0;
  logic [16*WORD-1:0] io_out;
  logic [16*WORD-1:0] ref_io_out = '0;
`endif

  int n_tests = 0;
  int n_fail = 0;
  int seen_pulses = 0;
  int exp_pulses = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .WORD    (WORD),
    .SIZE_LOG(SIZE_LOG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .ram_address (ram_address),
    .ram_data_in (ram_data_in),
    .ram_data_out(ram_data_out)
`ifdef MEM_ACCESS_IO_MAP_EN
    ,
    .io_in       (io_in),
    .io_out      (io_out)
`endif
  );

  // Registered-read RAM: data appears one cycle after ram_read.
  always @(posedge clk) begin
    if (ram_write) ram[ram_address] <= ram_data_in;
    if (ram_read) ram_data_out <= ram[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) seen_pulses++;
    if (!reset) chk("rw_exclusive", 32'(ram_read & ram_write), 32'(0));
  end

  function automatic bit is_io(input logic [SIZE_LOG-1:0] a);
    return IO_EN && (int'(a) >= DEPTH - 16);
  endfunction

  function automatic logic [WORD-1:0] ref_load(input logic [SIZE_LOG-1:0] a);
`ifdef MEM_ACCESS_IO_MAP_EN
    if (is_io(a)) return io_in[int'(a[3:0])*WORD +: WORD];
`endif
    return ref_mem[a];
  endfunction

  function automatic logic [SIZE_LOG-1:0] rand_addr();
    if ($urandom_range(3) == 0) return SIZE_LOG'(DEPTH - 32 + int'($urandom_range(31)));
    return SIZE_LOG'($urandom_range(DEPTH - 1));
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) chk("ready_timeout", 32'(0), 32'(1));
  endtask

  task automatic do_store(input logic [SIZE_LOG-1:0] a, input logic [WORD-1:0] d);
    bit io;
    io = is_io(a);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = SIZE_LOG'($urandom); req_wdata = WORD'($urandom);
    chk("st_ram_write", 32'(ram_write), 32'(!io));
    chk("st_ram_read", 32'(ram_read), 32'(0));
    chk("st_ready_busy", 32'(req_ready), 32'(0));
    if (!io) begin
      chk("st_ram_address", 32'(ram_address), 32'(a));
      chk("st_ram_data_in", 32'(ram_data_in), 32'(d));
      ref_mem[a] = d;
    end
`ifdef MEM_ACCESS_IO_MAP_EN
    else ref_io_out[int'(a[3:0])*WORD +: WORD] = d;
`endif
    @(negedge clk);
    chk("st_ready_back", 32'(req_ready), 32'(1));
    chk("st_ram_write_off", 32'(ram_write), 32'(0));
`ifdef MEM_ACCESS_IO_MAP_EN
    chk("io_out", 32'(io_out), 32'(ref_io_out));
`endif
  endtask

  task automatic do_load(input logic [SIZE_LOG-1:0] a);
    bit io;
    logic [WORD-1:0] exp;
    io = is_io(a);
    exp = ref_load(a);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = a;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = SIZE_LOG'($urandom);
    chk("ld_ram_read", 32'(ram_read), 32'(!io));
    chk("ld_ram_write", 32'(ram_write), 32'(0));
    if (!io) chk("ld_ram_address", 32'(ram_address), 32'(a));
    chk("ld_rsp_early", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    exp_pulses++;
    chk("ld_rsp_valid", 32'(rsp_valid), 32'(1));
    chk("ld_rsp_data", 32'(rsp_data), 32'(exp));
    chk("ld_ready_busy", 32'(req_ready), 32'(0));
    chk("ld_ram_read_off", 32'(ram_read), 32'(0));
    @(negedge clk);
    chk("ld_rsp_pulse_end", 32'(rsp_valid), 32'(0));
    chk("ld_ready_back", 32'(req_ready), 32'(1));
    chk("ld_rsp_data_held", 32'(rsp_data), 32'(exp));
  endtask

  task automatic burst_loads();
    int acc_t[$];
    logic [WORD-1:0] expq[$];
    int naccepts = 0;
    bit just_acc;
    req_valid = 1'b1; req_write = 1'b0; req_addr = SIZE_LOG'($urandom_range(DEPTH - 257));
    for (int c = 0; c < 16; c++) begin
      just_acc = 1'b0;
      if (rsp_valid === 1'b1) begin
        if (expq.size() == 0) chk("burst_extra_rsp", 32'(1), 32'(0));
        else chk("burst_rsp_data", 32'(rsp_data), 32'(expq.pop_front()));
      end
      if (req_ready === 1'b1 && req_valid) begin
        acc_t.push_back(c);
        expq.push_back(ref_load(req_addr));
        naccepts++;
        exp_pulses++;
        just_acc = 1'b1;
      end
      @(negedge clk);
      if (naccepts == 4) req_valid = 1'b0;
      else if (just_acc) req_addr = SIZE_LOG'($urandom_range(DEPTH - 257));
    end
    chk("burst_accepts", 32'(acc_t.size()), 32'(4));
    for (int i = 1; i < acc_t.size(); i++) chk("burst_gap", 32'(acc_t[i] - acc_t[i-1]), 32'(3));
    chk("burst_rsp_left", 32'(expq.size()), 32'(0));
  endtask

  task automatic abort_load();
    wait_ready();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h005;
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    chk("abort_rsp_valid_rst", 32'(rsp_valid), 32'(0));
    chk("abort_ready", 32'(req_ready), 32'(1));
    @(negedge clk);
    chk("abort_ready_release", 32'(req_ready), 32'(1));
    chk("abort_rsp_valid_after", 32'(rsp_valid), 32'(0));
    chk("abort_rsp_data", 32'(rsp_data), 32'(0));
    chk("abort_ram_read", 32'(ram_read), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    chk("rst_ram_read", 32'(ram_read), 32'(0));
    chk("rst_ram_write", 32'(ram_write), 32'(0));
    chk("rst_ram_address", 32'(ram_address), 32'(0));
    chk("rst_ram_data_in", 32'(ram_data_in), 32'(0));
`ifdef MEM_ACCESS_IO_MAP_EN
    chk("rst_io_out", 32'(io_out), 32'(0));
`endif
    reset = 1'b0;
    @(negedge clk);
    chk("release_ready", 32'(req_ready), 32'(1));

    do_store(12'h005, 1'b1);
    do_load(12'h005);
    chk("ram_0x005", 32'(ram[12'h005]), 32'(1));

    do_store(12'hFFF, 1'b1);
    do_load(12'hFFF);
    if (!IO_EN) chk("ram_0xFFF", 32'(ram[12'hFFF]), 32'(1));

`ifdef MEM_ACCESS_IO_MAP_EN
    do_store(12'hFF3, 1'b1);
    chk("io_out3", 32'(io_out[3]), 32'(1));
    io_in = (16*WORD)'(16'h0080);
    do_load(12'hFF7);
    chk("io_load_bit7", 32'(rsp_data), 32'(1));
`endif

    burst_loads();
    abort_load();

    for (int i = 0; i < 150; i++) begin
      logic [SIZE_LOG-1:0] a;
      a = rand_addr();
`ifdef MEM_ACCESS_IO_MAP_EN
      io_in = (16*WORD)'($urandom);
`endif
      if ($urandom_range(1) == 1) do_store(a, WORD'($urandom));
      else do_load(a);
    end

    repeat (2) @(negedge clk);
    chk("rsp_pulse_count", 32'(seen_pulses), 32'(exp_pulses));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
